// File: rtl/nand_target_emu.sv
// nand_target_emu: ONFI-style NAND flash target emulator (device side of the pin bus).
// Serves RESET (FFh), READ ID (90h), READ STATUS (70h), PAGE READ (00h/30h),
// PAGE PROGRAM (80h/10h) and BLOCK ERASE (60h/D0h) against a small on-chip array.
// Optional macro NAND_EMU_PARAM_PAGE_EN adds READ PARAMETER PAGE (ECh).
// PAGE_BYTES, NUM_PAGES and PPB are assumed to be powers of two, with
// 256 <= PAGE_BYTES <= 65536, 2 <= NUM_PAGES <= 256 and 2 <= PPB < NUM_PAGES.
// Handshake: every NAND pin is oversampled on clk; a bus cycle is recognised on
// the synchronized rising edge of nWE (or nRE for reads) while nCE is low.
module nand_target_emu #(
   parameter int          PAGE_BYTES = 512,
   parameter int          NUM_PAGES  = 16,
   parameter int          PPB        = 4,
   parameter int          TBUSY      = 64,
   parameter logic [39:0] ID_BYTES   = 40'h86_03_FF_E5_2C
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        nand_cle,
   input  logic        nand_ale,
   input  logic        nand_nwe,
   input  logic        nand_nre,
   input  logic        nand_nce,
   input  logic        nand_nwp,
   output logic        nand_rnb,
   inout  wire  [15:0] nand_data
);

   localparam int CW  = $clog2(PAGE_BYTES);
   localparam int RW  = $clog2(NUM_PAGES);
   localparam int PBW = $clog2(PPB);
   localparam int BW  = $clog2(TBUSY + 1);
   localparam logic [BW-1:0] BUSY_LOAD = BW'(TBUSY - 1);
   localparam logic [31:0]   PB32      = 32'(PAGE_BYTES);

   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ID      = 8'h90;
   localparam logic [7:0] CMD_STATUS  = 8'h70;
   localparam logic [7:0] CMD_READ    = 8'h00;
   localparam logic [7:0] CMD_READ_GO = 8'h30;
   localparam logic [7:0] CMD_PROG    = 8'h80;
   localparam logic [7:0] CMD_PROG_GO = 8'h10;
   localparam logic [7:0] CMD_ERASE   = 8'h60;
   localparam logic [7:0] CMD_ERAS_GO = 8'hD0;
   localparam logic [7:0] CMD_PARAM   = 8'hEC;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DIN, S_BUSY, S_DOUT} state_t;
   typedef enum logic [2:0] {OP_NONE, OP_READ, OP_PROG, OP_ERASE, OP_ID, OP_PARAM} op_t;
   typedef enum logic [1:0] {M_ID, M_STATUS, M_PAGE, M_PARAM} mode_t;
   typedef enum logic [1:0] {P_NONE, P_PROG, P_ERASE} pend_t;

   // synchronizer stages and edge-detect history
   logic [1:0] cle_sr, ale_sr, nwe_sr, nre_sr, nce_sr, nwp_sr;
   logic [7:0] din_m, din_s;
   logic       nwe_d, nre_d;
   logic       cle_s, ale_s, nwe_s, nre_s, nce_s, nwp_s;
   logic       we_rise, re_rise, cmd_ev, addr_ev, data_ev, din_wr;

   // FSM and transfer state
   state_t          state;
   op_t             op;
   mode_t           mode, busy_mode;
   pend_t           pend;
   logic [2:0]      acnt, need, id_idx;
   logic [CW-1:0]   col;
   logic [7:0]      col_lo;
   logic [RW-1:0]   row, pend_row;
   logic [RW-PBW-1:0] blk;
   logic [BW-1:0]   busy_cnt;
   logic            busy_dout, stat_busy, fail;
   logic [PAGE_BYTES-1:0] dirty;

   // storage: page array plus program staging buffer (no reset, survives nreset)
   logic [7:0] mem  [0:NUM_PAGES*PAGE_BYTES-1];
   logic [7:0] pbuf [0:PAGE_BYTES-1];

   logic       busy_done, commit_prog, commit_erase;
   logic [7:0] status_byte, out_byte, dout_q;
   logic       oe_q;
   logic       unused_hi;

   assign cle_s = cle_sr[1];
   assign ale_s = ale_sr[1];
   assign nwe_s = nwe_sr[1];
   assign nre_s = nre_sr[1];
   assign nce_s = nce_sr[1];
   assign nwp_s = nwp_sr[1];

   // Upper data lanes are output-only from the target's point of view.
   assign unused_hi = ^nand_data[15:8];

   assign we_rise = nwe_s & ~nwe_d & ~nce_s;
   assign re_rise = nre_s & ~nre_d & ~nce_s;
   assign cmd_ev  = we_rise &  cle_s & ~ale_s;
   assign addr_ev = we_rise &  ale_s & ~cle_s;
   assign data_ev = we_rise & ~cle_s & ~ale_s;
   assign din_wr  = data_ev && (state == S_DIN);

   assign need = (op == OP_READ || op == OP_PROG) ? 3'd5 :
                 (op == OP_ERASE)                  ? 3'd3 : 3'd1;

   // A reset command arriving on the last busy cycle cancels the array update.
   assign busy_done    = (state == S_BUSY) && (busy_cnt == '0) &&
                         !(cmd_ev && din_s == CMD_RESET);
   assign commit_prog  = busy_done && (pend == P_PROG);
   assign commit_erase = busy_done && (pend == P_ERASE);
   assign blk          = pend_row[RW-1:PBW];

   // Bit 5 is held 0 so the byte reads C0h idle, 80h busy, 41h after a protected program.
   assign status_byte = {nwp_s, nand_rnb, 5'b00000, fail};

`ifdef NAND_EMU_PARAM_PAGE_EN
   function automatic logic [7:0] param_byte(input logic [7:0] idx);
      case (idx)
         8'd0:    param_byte = 8'h4F;
         8'd1:    param_byte = 8'h4E;
         8'd2:    param_byte = 8'h46;
         8'd3:    param_byte = 8'h49;
         8'd80:   param_byte = PB32[7:0];
         8'd81:   param_byte = PB32[15:8];
         8'd82:   param_byte = PB32[23:16];
         8'd83:   param_byte = PB32[31:24];
         default: param_byte = 8'h00;
      endcase
   endfunction
`endif

   // Two-flop synchronizers for every pin plus one history flop for strobe edges.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cle_sr <= 2'b00;
         ale_sr <= 2'b00;
         nwe_sr <= 2'b11;
         nre_sr <= 2'b11;
         nce_sr <= 2'b11;
         nwp_sr <= 2'b11;
         din_m  <= 8'h00;
         din_s  <= 8'h00;
         nwe_d  <= 1'b1;
         nre_d  <= 1'b1;
      end else begin
         cle_sr <= {cle_sr[0], nand_cle};
         ale_sr <= {ale_sr[0], nand_ale};
         nwe_sr <= {nwe_sr[0], nand_nwe};
         nre_sr <= {nre_sr[0], nand_nre};
         nce_sr <= {nce_sr[0], nand_nce};
         nwp_sr <= {nwp_sr[0], nand_nwp};
         din_m  <= nand_data[7:0];
         din_s  <= din_m;
         nwe_d  <= nwe_sr[1];
         nre_d  <= nre_sr[1];
      end
   end

   // Main command FSM: busy countdown first, bus events afterwards so they take priority.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= S_IDLE;
         op        <= OP_NONE;
         mode      <= M_STATUS;
         busy_mode <= M_PAGE;
         pend      <= P_NONE;
         acnt      <= '0;
         id_idx    <= '0;
         col       <= '0;
         col_lo    <= '0;
         row       <= '0;
         pend_row  <= '0;
         busy_cnt  <= '0;
         busy_dout <= 1'b0;
         stat_busy <= 1'b0;
         fail      <= 1'b0;
         dirty     <= '0;
         nand_rnb  <= 1'b1;
      end else begin
         if (state == S_BUSY) begin
            if (busy_cnt == '0) begin
               nand_rnb  <= 1'b1;
               stat_busy <= 1'b0;
               pend      <= P_NONE;
               if (busy_dout) begin
                  state <= S_DOUT;
                  mode  <= busy_mode;
               end else begin
                  state <= S_IDLE;
               end
            end else begin
               busy_cnt <= busy_cnt - 1'b1;
            end
         end

         if (cmd_ev) begin
            if (din_s == CMD_RESET) begin
               state     <= S_BUSY;
               busy_cnt  <= BUSY_LOAD;
               nand_rnb  <= 1'b0;
               busy_dout <= 1'b0;
               stat_busy <= 1'b0;
               pend      <= P_NONE;
               op        <= OP_NONE;
            end else if (din_s == CMD_STATUS) begin
               if (state == S_BUSY) begin
                  stat_busy <= 1'b1;
               end else begin
                  state <= S_DOUT;
                  mode  <= M_STATUS;
                  op    <= OP_NONE;
               end
            end else if (state != S_BUSY) begin
               acnt <= '0;
               op   <= OP_NONE;
               case (din_s)
                  CMD_ID:    begin state <= S_ADDR; op <= OP_ID;    end
                  CMD_READ:  begin state <= S_ADDR; op <= OP_READ;  end
                  CMD_ERASE: begin state <= S_ADDR; op <= OP_ERASE; end
                  CMD_PROG: begin
                     state <= S_ADDR;
                     op    <= OP_PROG;
                     dirty <= '0;
                  end
`ifdef NAND_EMU_PARAM_PAGE_EN
                  CMD_PARAM: begin state <= S_ADDR; op <= OP_PARAM; end
`endif
                  CMD_READ_GO: begin
                     if (state == S_ADDR && op == OP_READ) begin
                        state     <= S_BUSY;
                        busy_cnt  <= BUSY_LOAD;
                        nand_rnb  <= 1'b0;
                        busy_dout <= 1'b1;
                        busy_mode <= M_PAGE;
                        stat_busy <= 1'b0;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
                  CMD_PROG_GO, CMD_ERAS_GO: begin
                     if ((din_s == CMD_PROG_GO && state == S_DIN  && op == OP_PROG) ||
                         (din_s == CMD_ERAS_GO && state == S_ADDR && op == OP_ERASE)) begin
                        state     <= S_BUSY;
                        busy_cnt  <= BUSY_LOAD;
                        nand_rnb  <= 1'b0;
                        busy_dout <= 1'b0;
                        stat_busy <= 1'b0;
                        pend_row  <= row;
                        fail      <= ~nwp_s;
                        if (!nwp_s)                    pend <= P_NONE;
                        else if (din_s == CMD_PROG_GO) pend <= P_PROG;
                        else                           pend <= P_ERASE;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end else if (addr_ev) begin
            if (state == S_ADDR && acnt < need) begin
               acnt <= acnt + 3'd1;
               if (op == OP_READ || op == OP_PROG) begin
                  if (acnt == 3'd0) begin
                     col_lo <= din_s;
                     col    <= CW'({8'h00, din_s});
                  end else if (acnt == 3'd1) begin
                     col <= CW'({din_s, col_lo});
                  end else if (acnt == 3'd2) begin
                     row <= RW'(din_s);
                  end
               end else if (op == OP_ERASE && acnt == 3'd0) begin
                  row <= RW'(din_s);
               end
               if (acnt == need - 3'd1) begin
                  case (op)
                     OP_PROG: state <= S_DIN;
                     OP_ID: begin
                        state  <= S_DOUT;
                        mode   <= M_ID;
                        id_idx <= '0;
                     end
                     OP_PARAM: begin
                        state     <= S_BUSY;
                        busy_cnt  <= BUSY_LOAD;
                        nand_rnb  <= 1'b0;
                        busy_dout <= 1'b1;
                        busy_mode <= M_PARAM;
                        stat_busy <= 1'b0;
                        col       <= '0;
                     end
                     default: ;
                  endcase
               end
            end
         end else if (data_ev) begin
            if (state == S_DIN) begin
               dirty[col] <= 1'b1;
               col        <= col + 1'b1;
            end
         end else if (re_rise && state == S_DOUT) begin
            case (mode)
               M_ID:    id_idx <= (id_idx == 3'd4) ? 3'd0 : id_idx + 3'd1;
               M_PAGE:  col    <= col + 1'b1;
               M_PARAM: col    <= CW'(col[7:0] + 8'd1);
               default: ;
            endcase
         end
      end
   end

   // Array and staging buffer updates; program/erase land only when busy completes.
   always_ff @(posedge clk) begin
      if (din_wr) pbuf[col] <= din_s;
      if (commit_prog) begin
         for (int i = 0; i < PAGE_BYTES; i++) begin
            if (dirty[i]) mem[{pend_row, CW'(i)}] <= pbuf[i];
         end
      end
      if (commit_erase) begin
         for (int p = 0; p < PPB; p++) begin
            for (int i = 0; i < PAGE_BYTES; i++) begin
               mem[{blk, PBW'(p), CW'(i)}] <= 8'hFF;
            end
         end
      end
   end

   // Select the byte presented on a read cycle.
   always_comb begin
      out_byte = 8'h00;
      if (state == S_BUSY || mode == M_STATUS) begin
         out_byte = status_byte;
      end else begin
         case (mode)
            M_ID:    out_byte = ID_BYTES[{id_idx, 3'b000} +: 8];
            M_PAGE:  out_byte = mem[{row, col}];
`ifdef NAND_EMU_PARAM_PAGE_EN
            M_PARAM: out_byte = param_byte(col[7:0]);
`endif
            default: out_byte = 8'h00;
         endcase
      end
   end

   // Registered read data and bus enable; the bus is driven only while nRE is low.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         dout_q <= 8'h00;
         oe_q   <= 1'b0;
      end else begin
         dout_q <= out_byte;
         oe_q   <= ~nce_s & ~nre_s &
                   ((state == S_DOUT) || (state == S_BUSY && stat_busy));
      end
   end

   assign nand_data = oe_q ? {8'h00, dout_q} : 16'hzzzz;

endmodule

// File: tb/tb_nand_target_emu.sv
// tb_nand_target_emu: directed bench for nand_target_emu driving ONFI bus cycles.
module tb_nand_target_emu;

   logic        clk = 1'b0;
   logic        nreset, cle, ale, nwe, nre, nce, nwp;
   logic        drv_en;
   logic [7:0]  drv_data;
   wire  [15:0] nand_data;
   wire         nand_rnb;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          low_total = 0;
   int          t0;
   logic [7:0]  exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   assign nand_data = drv_en ? {8'h00, drv_data} : 16'hzzzz;

   nand_target_emu dut (
      .clk       (clk),
      .nreset    (nreset),
      .nand_cle  (cle),
      .nand_ale  (ale),
      .nand_nwe  (nwe),
      .nand_nre  (nre),
      .nand_nce  (nce),
      .nand_nwp  (nwp),
      .nand_rnb  (nand_rnb),
      .nand_data (nand_data)
   );

   // running count of clocks spent busy, sampled mid-cycle
   always @(negedge clk) if (nand_rnb === 1'b0) low_total++;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic bus_cycle(input logic c, input logic a, input logic [7:0] b);
      @(posedge clk);
      cle = c; ale = a; drv_data = b; drv_en = 1'b1;
      @(posedge clk);
      nwe = 1'b0;
      repeat (4) @(posedge clk);
      nwe = 1'b1;
      repeat (4) @(posedge clk);
      cle = 1'b0; ale = 1'b0; drv_en = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] b);  bus_cycle(1'b1, 1'b0, b); endtask
   task automatic addr(input logic [7:0] b); bus_cycle(1'b0, 1'b1, b); endtask
   task automatic din(input logic [7:0] b);  bus_cycle(1'b0, 1'b0, b); endtask

   task automatic page_addr(input logic [15:0] c, input logic [7:0] r);
      addr(c[7:0]); addr(c[15:8]); addr(r); addr(8'h00); addr(8'h00);
   endtask

   task automatic rd(output logic [15:0] v);
      @(posedge clk);
      nre = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      v = nand_data;
      @(posedge clk);
      nre = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] e);
      logic [15:0] v;
      rd(v);
      chk(tag, v, {8'h00, e});
   endtask

   // scoreboard: drain expected bytes against consecutive read cycles
   task automatic rd_queue(input string tag);
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rd_chk(tag, e);
      end
   endtask

   task automatic wait_ready(input string tag);
      int i = 0;
      while (nand_rnb !== 1'b1 && i < 1000) begin
         @(negedge clk);
         i++;
      end
      chk(tag, {15'd0, nand_rnb}, 16'd1);
   endtask

   task automatic read_page(input logic [15:0] c, input logic [7:0] r);
      cmd(8'h00); page_addr(c, r); cmd(8'h30);
      wait_ready("read_ready");
   endtask

   task automatic status_chk(input string tag, input logic [7:0] e);
      cmd(8'h70);
      rd_chk(tag, e);
   endtask

   initial begin
      nreset = 1'b0; cle = 1'b0; ale = 1'b0; nwe = 1'b1; nre = 1'b1;
      nce = 1'b0; nwp = 1'b1; drv_en = 1'b0; drv_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_rnb", {15'd0, nand_rnb}, 16'd1);
      repeat (2) @(posedge clk);
      nreset = 1'b1;
      repeat (3) @(posedge clk);
      status_chk("reset_status", 8'hC0);

      // READ ID with wrap after five bytes
      cmd(8'h90); addr(8'h00);
      exp_q = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86, 8'h2C};
      rd_queue("read_id");

      // program page 3 and check busy length and status
      t0 = low_total;
      cmd(8'h80); page_addr(16'h0000, 8'h03); din(8'hA5); din(8'h5A); cmd(8'h10);
      wait_ready("prog_ready");
      chk("prog_busy_len", 16'(low_total - t0), 16'd64);
      status_chk("prog_status", 8'hC0);
      t0 = low_total;
      read_page(16'h0000, 8'h03);
      chk("read_busy_len", 16'(low_total - t0), 16'd64);
      exp_q = '{8'hA5, 8'h5A};
      rd_queue("readback_p3");

      // column wrap at the page end
      cmd(8'h80); page_addr(16'h01FF, 8'h05); din(8'h11); din(8'h22); cmd(8'h10);
      wait_ready("wrap_prog_ready");
      read_page(16'h01FF, 8'h05);
      exp_q = '{8'h11, 8'h22};
      rd_queue("col_wrap_p5");

      // write protect leaves page 1 untouched and flags fail
      cmd(8'h80); page_addr(16'h0000, 8'h01); din(8'h77); cmd(8'h10);
      wait_ready("p1_prog_ready");
      nwp = 1'b0;
      cmd(8'h80); page_addr(16'h0000, 8'h01); din(8'h11); cmd(8'h10);
      wait_ready("wp_ready");
      status_chk("wp_status", 8'h41);
      nwp = 1'b1;
      read_page(16'h0000, 8'h01);
      rd_chk("wp_unchanged", 8'h77);

      // erase block holding row 2 (pages 0-3)
      cmd(8'h60); addr(8'h02); addr(8'h00); addr(8'h00); cmd(8'hD0);
      wait_ready("erase_ready");
      status_chk("erase_status", 8'hC0);
      read_page(16'h0000, 8'h03);
      exp_q = '{8'hFF, 8'hFF};
      rd_queue("erased_p3");
      for (int p = 0; p < 3; p++) begin
         read_page(16'h0000, 8'(p));
         rd_chk("erased_p012", 8'hFF);
      end
      read_page(16'h01FF, 8'h05);
      rd_chk("other_block_kept", 8'h11);

      // status during busy, then reset command restarts busy and drops the program
      cmd(8'h60); addr(8'h08); addr(8'h00); addr(8'h00); cmd(8'hD0);
      wait_ready("erase2_ready");
      cmd(8'h80); page_addr(16'h0000, 8'h08); din(8'h3C); cmd(8'h10);
      repeat (3) @(posedge clk);
      status_chk("busy_status", 8'h80);
      t0 = low_total;
      cmd(8'hFF);
      wait_ready("ff_ready");
      chk("ff_restart", {15'd0, (low_total - t0) > 64}, 16'd1);
      read_page(16'h0000, 8'h08);
      rd_chk("prog_aborted", 8'hFF);

      // confirm without setup does nothing
      t0 = low_total;
      cmd(8'h30);
      repeat (10) @(posedge clk);
      chk("orphan_confirm", 16'(low_total - t0), 16'd0);

`ifdef NAND_EMU_PARAM_PAGE_EN
      t0 = low_total;
      cmd(8'hEC); addr(8'h00);
      wait_ready("param_ready");
      chk("param_busy_len", 16'(low_total - t0), 16'd64);
      exp_q = '{8'h4F, 8'h4E, 8'h46, 8'h49};
      rd_queue("param_page");
`else
      t0 = low_total;
      cmd(8'hEC); addr(8'h00);
      repeat (10) @(posedge clk);
      chk("ec_unknown", 16'(low_total - t0), 16'd0);
`endif

      // chip enable high holds the read position
      cmd(8'h90); addr(8'h00);
      rd_chk("nce_id0", 8'h2C);
      @(posedge clk); nce = 1'b1;
      repeat (3) @(posedge clk); nre = 1'b0;
      repeat (5) @(posedge clk); nre = 1'b1;
      repeat (5) @(posedge clk); nce = 1'b0;
      repeat (3) @(posedge clk);
      rd_chk("nce_hold", 8'hE5);
      rd_chk("nce_resume", 8'hFF);

      // hardware reset mid-busy releases rnb and drops the array write
      cmd(8'h80); page_addr(16'h0000, 8'h09); din(8'h5A); cmd(8'h10);
      repeat (5) @(posedge clk);
      nreset = 1'b0;
      @(negedge clk);
      chk("nreset_rnb", {15'd0, nand_rnb}, 16'd1);
      repeat (2) @(posedge clk);
      nreset = 1'b1;
      repeat (3) @(posedge clk);
      status_chk("post_reset_status", 8'hC0);
      read_page(16'h0000, 8'h09);
      rd_chk("reset_drop", 8'hFF);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
